// File: rtl/state_load_arbiter.sv
// Two-requester, round-robin arbiter for one shared 4-bit state register.
// A load takes a GRANT cycle (data capture) and a WRITE cycle (commit). A preset takes a single cycle.
module state_load_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  input  logic       preset_req,
  output logic [1:0] grant,
  output logic [1:0] ack,
  output logic       preset_ack,
  output logic [3:0] q,
  output logic       busy,
  output logic [3:0] load_count
);

  localparam logic [3:0] RESET_VALUE  = 4'b1101;
  localparam logic [3:0] PRESET_VALUE = 4'b0110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    WRITE  = 2'd2,
    PRESET = 2'd3
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       last;
  logic       winner;
  logic [3:0] hold;

  // last doubles as the active requester index for the whole GRANT/WRITE transaction
  always_comb begin
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (preset_req) begin
          next_state = PRESET;
        end else if (req != 2'b00) begin
          next_state = GRANT;
        end
      end
      GRANT:   next_state = WRITE;
      WRITE:   next_state = IDLE;
      PRESET:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last       <= 1'b1;
      hold       <= 4'h0;
      q          <= RESET_VALUE;
      load_count <= 4'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!preset_req && (req != 2'b00)) begin
            last <= winner;
          end
        end
        GRANT: begin
          hold <= last ? data1 : data0;
        end
        WRITE: begin
          q          <= hold;
          load_count <= load_count + 4'h1;
        end
        PRESET: begin
          q          <= PRESET_VALUE;
          load_count <= load_count + 4'h1;
        end
        default: begin
          hold <= hold;
        end
      endcase
    end
  end

  always_comb begin
    grant      = 2'b00;
    ack        = 2'b00;
    preset_ack = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      GRANT:   grant      = last ? 2'b10 : 2'b01;
      WRITE:   ack        = last ? 2'b10 : 2'b01;
      PRESET:  preset_ack = 1'b1;
      default: grant      = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_state_load_arbiter.sv
// Bench for state_load_arbiter: directed scenarios and random traffic checked every cycle
// against a transaction-level model (remaining-cycle countdown per job).
module tb_state_load_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [3:0] data0;
  logic [3:0] data1;
  logic       preset_req;
  logic [1:0] grant;
  logic [1:0] ack;
  logic       preset_ack;
  logic [3:0] q;
  logic       busy;
  logic [3:0] load_count;

  int total;
  int bad;

  logic [13:0] outs;
  assign outs = {grant, ack, preset_ack, busy, q, load_count};

  localparam logic [13:0] RESET_OUTS = {2'b00, 2'b00, 1'b0, 1'b0, 4'hD, 4'h0};

  state_load_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .preset_req (preset_req),
    .grant      (grant),
    .ack        (ack),
    .preset_ack (preset_ack),
    .q          (q),
    .busy       (busy),
    .load_count (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a job is either a preset (1 cycle left) or a load (2 cycles left).
  int         m_left;
  bit         m_is_preset;
  bit         m_w;
  bit         m_last;
  logic [3:0] m_held;
  logic [3:0] m_q;
  logic [3:0] m_cnt;

  initial begin
    m_left = 0; m_is_preset = 0; m_w = 0; m_last = 1; m_held = 0; m_q = 4'hD; m_cnt = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_left = 0; m_is_preset = 0; m_last = 1; m_q = 4'hD; m_cnt = 0;
      end else if (m_left == 0) begin
        if (preset_req) begin
          m_is_preset = 1; m_left = 1;
        end else if (req != 2'b00) begin
          m_is_preset = 0;
          m_w = (req == 2'b11) ? !m_last : req[1];
          m_last = m_w;
          m_left = 2;
        end
      end else if (!m_is_preset && m_left == 2) begin
        m_held = m_w ? data1 : data0;
        m_left = 1;
      end else begin
        m_q = m_is_preset ? 4'b0110 : m_held;
        m_cnt = m_cnt + 4'h1;
        m_left = 0;
      end
    end
  end

  function automatic logic [13:0] model_outs();
    logic [1:0] g;
    logic [1:0] a;
    logic       p;
    g = (!m_is_preset && m_left == 2) ? (m_w ? 2'b10 : 2'b01) : 2'b00;
    a = (!m_is_preset && m_left == 1) ? (m_w ? 2'b10 : 2'b01) : 2'b00;
    p = m_is_preset && m_left == 1;
    return {g, a, p, m_left != 0, m_q, m_cnt};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; req = 2'b00; preset_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (outs !== RESET_OUTS) begin
      bad++; $display("FAIL reset_state: got %h want %h", outs, RESET_OUTS);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_load();
    req = 2'b01; data0 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) req = 2'b00;
      total++;
      if (outs !== model_outs()) begin
        bad++; $display("FAIL single_cycle%0d: got %h want %h", i, outs, model_outs());
      end
      total++;
      if (i == 0 && grant !== 2'b01) begin bad++; $display("FAIL single_grant: got %b want 01", grant); end
      else if (i == 1 && ack !== 2'b01) begin bad++; $display("FAIL single_ack: got %b want 01", ack); end
      else if (i == 2 && {q, load_count} !== {4'b1010, 4'h1}) begin
        bad++; $display("FAIL single_commit: got q=%b cnt=%0d want q=1010 cnt=1", q, load_count);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    apply_reset();
    req = 2'b11; data0 = 4'b0011; data1 = 4'b1100;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      total++;
      if (outs !== model_outs()) begin
        bad++; $display("FAIL rr_cycle%0d: got %h want %h", i, outs, model_outs());
      end
      if (i % 3 == 0) begin
        want = (i == 6) ? 4'b1100 : 4'b0011;
        total++;
        if (q !== want) begin bad++; $display("FAIL rr_order%0d: got q=%b want %b", i, q, want); end
      end
    end
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_preset_priority();
    apply_reset();
    preset_req = 1'b1; req = 2'b10; data1 = 4'b1001;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      preset_req = 1'b0;
      if (i == 3) req = 2'b00;
      total++;
      if (outs !== model_outs()) begin
        bad++; $display("FAIL preset_cycle%0d: got %h want %h", i, outs, model_outs());
      end
      total++;
      if (i == 1 && preset_ack !== 1'b1) begin bad++; $display("FAIL preset_ack: got %b want 1", preset_ack); end
      else if (i == 2 && q !== 4'b0110) begin bad++; $display("FAIL preset_q: got %b want 0110", q); end
      else if (i == 3 && grant !== 2'b10) begin bad++; $display("FAIL preset_then_grant: got %b want 10", grant); end
      else if (i == 5 && q !== 4'b1001) begin bad++; $display("FAIL preset_then_load: got %b want 1001", q); end
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    preset_req = 1'b1;
    @(negedge clk);
    preset_req = 1'b0;
    @(negedge clk);
    req = 2'b01; data0 = 4'($urandom_range(0, 15));
    @(negedge clk);
    @(negedge clk);
    total++;
    if (outs !== {2'b00, 2'b01, 1'b0, 1'b1, 4'b0110, 4'h1}) begin
      bad++; $display("FAIL midwrite_setup: got %h want %h", outs, {2'b00, 2'b01, 1'b0, 1'b1, 4'b0110, 4'h1});
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (outs !== RESET_OUTS) begin bad++; $display("FAIL midwrite_reset: got %h want %h", outs, RESET_OUTS); end
    @(negedge clk);
    reset = 1'b0; req = 2'b00;
    @(negedge clk);
    total++;
    if (outs !== RESET_OUTS) begin bad++; $display("FAIL midwrite_noack: got %h want %h", outs, RESET_OUTS); end
  endtask

  task automatic test_wrap();
    apply_reset();
    req = 2'b11;
    for (int i = 1; i <= 51; i++) begin
      data0 = 4'($urandom); data1 = 4'($urandom);
      @(negedge clk);
      total++;
      if (outs !== model_outs()) begin
        bad++; $display("FAIL wrap_cycle%0d: got %h want %h", i, outs, model_outs());
      end
    end
    total++;
    if (load_count !== 4'h1) begin bad++; $display("FAIL wrap_count: got %0d want 1", load_count); end
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drop_during_grant();
    logic [3:0] d;
    apply_reset();
    d = 4'($urandom);
    req = 2'b01; data0 = d;
    @(negedge clk);
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL drop_grant: got %b want 01", grant); end
    req = 2'b00;
    @(negedge clk);
    total++;
    if (ack !== 2'b01) begin bad++; $display("FAIL drop_ack: got %b want 01", ack); end
    data0 = ~d;
    @(negedge clk);
    total++;
    if ({q, busy} !== {d, 1'b0}) begin bad++; $display("FAIL drop_commit: got q=%b busy=%b want q=%b busy=0", q, busy, d); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      req = 2'($urandom); preset_req = ($urandom_range(0, 7) == 0);
      data0 = 4'($urandom); data1 = 4'($urandom);
      @(negedge clk);
      total++;
      if (outs !== model_outs()) begin
        bad++; $display("FAIL random_cycle%0d: got %h want %h", i, outs, model_outs());
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; req = 2'b00; preset_req = 1'b0; data0 = 4'h0; data1 = 4'h0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_preset_priority();
    test_reset_mid_write();
    test_wrap();
    test_drop_during_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
